custom_pipe_unit: RTL and testbench
===================================

# custom_pipe_unit

Parametrised custom execution unit for CUSTOM-opcode instructions, with configurable pipeline latency, a credit-counted result queue, and fn3-selected operations. It attaches to the issue stage through a unit_issue_interface and to writeback through a unit_writeback_interface. It sustains one issue per cycle whenever the queue has room, and holds results until writeback accepts them.

## Interface
- LATENCY, 2: execute pipeline depth in cycles, from issue to the result becoming writeback-visible; legal range 1..8.
- FIFO_DEPTH, 4: maximum number of results in flight plus queued; must be ≥1, and a power of two.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- decode_stage  in  decode_packet_t  decode-stage instruction
- unit_needed  out  1  decoded instruction is CUSTOM
- uses_rs  out  REGFILE_READ_PORTS  RS1 and RS2 bits set for CUSTOM
- uses_rd  out  1  set for CUSTOM
- issue_stage  in  issue_packet_t  issue packet; fn3 is taken from here
- issue_stage_ready  in  1  issue stage holds a valid instruction
- rf  in  32×REGFILE_READ_PORTS  operand values rf[RS1], rf[RS2]
- issue  unit_issue_interface.unit  uses new_request, id and ready
- wb  unit_writeback_interface.unit  uses done, rd, id and ack

## Operation
- **Decode:** unit_needed, uses_rs[RS1], uses_rs[RS2] and uses_rd are all equal to (instruction inside {CUSTOM}). They are purely combinational.
- **fn3 operation select** (32-bit, wrap-around unless stated otherwise):
  - 000: rs1+rs2
  - 001: rs1−rs2
  - 010: rs1^rs2
  - 011: rs1+rs2 (see Configuration)
  - 100: signed min
  - 101: signed max
  - 110: unsigned min
  - 111: rs1 rotated left by rs2[4:0]
- **Result:** computed combinationally in the issue cycle, then carried through the pipeline together with id and a valid bit.
- **Pipeline:** LATENCY−1 stage registers feed the result queue; the queue write is the final stage.
  - Stage registers advance every cycle and never stall.
  - Credits guarantee queue space, so the pipeline never needs to stall.
- **Credit counter:** width $clog2(FIFO_DEPTH+1).
  - +1 on issue.new_request.
  - −1 on wb.done & wb.ack.
  - Both in the same cycle: no change.
  - issue.ready = (credits < FIFO_DEPTH). It is derived from registered state only; there is no combinational path from wb.ack.
- **Result queue:** circular buffer of FIFO_DEPTH entries {rd, id}.
  - Read and write pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.
  - A count register tracks occupancy.
  - wb.done = (count != 0).
  - wb.rd and wb.id are driven from the head entry.
  - Pop on wb.done & wb.ack.
  - Push and pop in the same cycle are both legal, including when count is 0 or FIFO_DEPTH.
- wb.ack while wb.done=0 is ignored.
- Results retire strictly in issue order.

## Timing
- **Reset** (rst high at a clock edge):
  - Credits, queue count, pointers and all stage valid bits go to 0.
  - After reset: issue.ready=1 and wb.done=0.
  - wb.rd and wb.id are not reset and are don't-care while wb.done=0.
  - Any in-flight or queued results are discarded.
- **Latency:** issue.new_request in cycle N → entry written at the end of cycle N+LATENCY−1 → wb.done=1 in cycle N+LATENCY, provided the queue was otherwise empty.
- **Throughput:** one result per cycle when FIFO_DEPTH ≥ LATENCY+1 and wb.ack is held high.
  - Smaller depths throttle issue.ready.
  - LATENCY=1 with FIFO_DEPTH=1 gives alternate-cycle issue under continuous ack.
- **Handshake:** wb.rd and wb.id stay stable while wb.done=1 and wb.ack=0.
- **Full credits:** issue.ready drops in the cycle after the FIFO_DEPTH-th issue. It rises in the cycle after the first ack.

## Configuration
- CUSTOM_PIPE_UNIT_SAT_EN
  - **Defined:** fn3 011 is signed saturating add. Overflow gives 32'h7FFFFFFF; underflow gives 32'h80000000. Overflow is detected from the operand sign bits and the result sign bit.
  - **Undefined:** fn3 011 is identical to 000 (wrap-around add), and no saturation logic is generated.

## Test plan
- **Single issue:** LATENCY=2; fn3=000, rs1=5, rs2=7, id=3, issued in cycle 10 → wb.done rises in cycle 12 with wb.rd=12, wb.id=3; ack in cycle 12 → wb.done=0 in cycle 13.
- **Back-pressure:** FIFO_DEPTH=4, wb.ack held at 0, issue every cycle.
  - Exactly 4 issues are accepted, then issue.ready=0.
  - Releasing ack drains the 4 results in issue order, and issue.ready returns high one cycle after the first ack.
- **Streaming:** LATENCY=2, FIFO_DEPTH=4, ack held high, 100 back-to-back random-fn3 issues → 100 consecutive wb.done cycles, all results matching a reference model, issue.ready never low.
- **Operations:**
  - fn3=100 with rs1=32'hFFFFFFFF, rs2=1 → 32'hFFFFFFFF.
  - fn3=110 with the same operands → 1.
  - fn3=111 with rs1=32'h80000001, rs2=4 → 32'h00000018.
- **Saturation:** fn3=011, rs1=32'h7FFFFFF0, rs2=32'h20.
  - Macro defined → 32'h7FFFFFFF.
  - Macro undefined → 32'h80000010.
- **Reset mid-operation:** 3 results queued and 1 in flight, then rst asserted for one cycle → the next cycle shows wb.done=0 and issue.ready=1, and no stale result ever appears.

Source files
------------

// File: rtl/custom_pipe_unit_if.sv
// Shared types and unit interfaces for custom_pipe_unit.
// Contains the package with the decode and issue packet types, plus the issue
// and writeback handshake interfaces.
package custom_pipe_unit_pkg;
    localparam int REGFILE_READ_PORTS = 2;
    localparam int RS1 = 0;
    localparam int RS2 = 1;
    localparam int ID_W = 3;

    // custom-0 major opcode; the upper instruction bits are don't-care
    localparam logic [31:0] CUSTOM = 32'b????_????_????_????_????_????_?000_1011;

    typedef struct packed {
        logic [31:0] instruction;
    } decode_packet_t;

    typedef struct packed {
        logic [2:0] fn3;
    } issue_packet_t;
endpackage

interface unit_issue_interface;
    import custom_pipe_unit_pkg::*;
    logic            new_request;
    logic [ID_W-1:0] id;
    logic            ready;

    modport unit   (input new_request, id, output ready);
    modport decode (output new_request, id, input ready);
endinterface

interface unit_writeback_interface;
    import custom_pipe_unit_pkg::*;
    logic            done;
    logic [31:0]     rd;
    logic [ID_W-1:0] id;
    logic            ack;

    modport unit (output done, rd, id, input ack);
    modport wb   (input done, rd, id, output ack);
endinterface

// File: rtl/custom_pipe_unit.sv
// custom_pipe_unit: execution unit for CUSTOM-opcode instructions.
// The fn3-selected result is computed in the issue cycle, travels through
// LATENCY-1 never-stalling stage registers and lands in a FIFO_DEPTH-entry
// result queue. A credit counter (issues minus retirements) guarantees
// queue space, so issue.ready depends only on registered state.
// Optional feature macro: CUSTOM_PIPE_UNIT_SAT_EN turns fn3=011 into a
// signed saturating add; without it fn3=011 is a plain wrap-around add.
module custom_pipe_unit
    import custom_pipe_unit_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  decode_packet_t                decode_stage,
    output logic                          unit_needed,
    output logic [REGFILE_READ_PORTS-1:0] uses_rs,
    output logic                          uses_rd,
    input  issue_packet_t                 issue_stage,
    input  logic                          issue_stage_ready,
    input  logic [31:0]                   rf [REGFILE_READ_PORTS],
    unit_issue_interface.unit             issue,
    unit_writeback_interface.unit         wb
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic            is_custom;
    logic            issue_fire;
    logic [31:0]     rs1;
    logic [31:0]     rs2;
    logic [31:0]     sum;
    logic [31:0]     rot;
    logic [31:0]     result_comb;
    logic            push_valid;
    logic [31:0]     push_rd;
    logic [ID_W-1:0] push_id;
    logic            pop;

    logic [31:0]     rd_mem [FIFO_DEPTH];
    logic [ID_W-1:0] id_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   credits_reg;

    // Decode: all usage flags follow the CUSTOM opcode match
    always_comb begin
        is_custom    = (decode_stage.instruction inside {CUSTOM});
        unit_needed  = is_custom;
        uses_rd      = is_custom;
        uses_rs      = '0;
        uses_rs[RS1] = is_custom;
        uses_rs[RS2] = is_custom;
    end

    // A request only counts when the issue stage really holds an instruction
    assign issue_fire = issue.new_request & issue_stage_ready;

`ifdef CUSTOM_PIPE_UNIT_SAT_EN
    logic        sat_ovf;
    logic [31:0] sat_sum;

    // Saturating add: overflow when operand signs agree but the sum sign differs
    always_comb begin
        sat_ovf = (rs1[31] == rs2[31]) && (sum[31] != rs1[31]);
        sat_sum = sat_ovf ? (rs1[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum;
    end
`endif

    // Issue-cycle operation select on fn3
    always_comb begin
        rs1 = rf[RS1];
        rs2 = rf[RS2];
        sum = rs1 + rs2;
        rot = (rs1 << rs2[4:0]) | (rs1 >> (6'd32 - {1'b0, rs2[4:0]}));
        result_comb = sum;
        case (issue_stage.fn3)
            3'b000: result_comb = sum;
            3'b001: result_comb = rs1 - rs2;
            3'b010: result_comb = rs1 ^ rs2;
`ifdef CUSTOM_PIPE_UNIT_SAT_EN
            3'b011: result_comb = sat_sum;
`else
            3'b011: result_comb = sum;
`endif
            3'b100: result_comb = ($signed(rs1) < $signed(rs2)) ? rs1 : rs2;
            3'b101: result_comb = ($signed(rs1) > $signed(rs2)) ? rs1 : rs2;
            3'b110: result_comb = (rs1 < rs2) ? rs1 : rs2;
            default: result_comb = rot;
        endcase
    end

    // Stage registers: each stage copies the previous one every cycle
    for (genvar gi = 0; gi < LATENCY - 1; gi++) begin : g_stage
        logic            valid_reg;
        logic [31:0]     rd_reg;
        logic [ID_W-1:0] id_reg;
        logic            in_valid;
        logic [31:0]     in_rd;
        logic [ID_W-1:0] in_id;

        if (gi == 0) begin : g_src
            assign in_valid = issue_fire;
            assign in_rd    = result_comb;
            assign in_id    = issue.id;
        end else begin : g_src
            assign in_valid = g_stage[gi-1].valid_reg;
            assign in_rd    = g_stage[gi-1].rd_reg;
            assign in_id    = g_stage[gi-1].id_reg;
        end

        // Only the valid bit is reset; payload is qualified by it
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg <= 1'b0;
            end else begin
                valid_reg <= in_valid;
            end
            rd_reg <= in_rd;
            id_reg <= in_id;
        end
    end

    if (LATENCY > 1) begin : g_push_pipe
        assign push_valid = g_stage[LATENCY-2].valid_reg;
        assign push_rd    = g_stage[LATENCY-2].rd_reg;
        assign push_id    = g_stage[LATENCY-2].id_reg;
    end else begin : g_push_direct
        assign push_valid = issue_fire;
        assign push_rd    = result_comb;
        assign push_id    = issue.id;
    end

    assign wb.done  = (count_reg != '0);
    assign pop      = wb.done & wb.ack;
    assign wb.rd    = rd_mem[rd_ptr_reg];
    assign wb.id    = id_mem[rd_ptr_reg];
    assign issue.ready = (credits_reg < CW'(FIFO_DEPTH));

    // Queue storage write; a push into the head slot while it is popped is safe
    always_ff @(posedge clk) begin
        if (push_valid) begin
            rd_mem[wr_ptr_reg] <= push_rd;
            id_mem[wr_ptr_reg] <= push_id;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_valid) begin
                wr_ptr_reg <= (FIFO_DEPTH == 1) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (FIFO_DEPTH == 1) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push_valid, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Credits: results issued but not yet retired by writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_reg <= '0;
        end else begin
            case ({issue_fire, pop})
                2'b10:   credits_reg <= credits_reg + 1'b1;
                2'b01:   credits_reg <= credits_reg - 1'b1;
                default: credits_reg <= credits_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_custom_pipe_unit.sv
// Testbench for custom_pipe_unit: table-driven operation vectors plus
// hand-written latency, back-pressure, streaming and reset sequences.
// Expected results go into a scoreboard queue at issue time and are
// compared when writeback retires them.
module tb_custom_pipe_unit;
    import custom_pipe_unit_pkg::*;

    localparam int LATENCY    = 2;
    localparam int FIFO_DEPTH = 4;

    logic                          clk = 1'b0;
    logic                          rst;
    decode_packet_t                decode_stage;
    logic                          unit_needed;
    logic [REGFILE_READ_PORTS-1:0] uses_rs;
    logic                          uses_rd;
    issue_packet_t                 issue_stage;
    logic                          issue_stage_ready;
    logic [31:0]                   rf [REGFILE_READ_PORTS];

    unit_issue_interface     issue_if ();
    unit_writeback_interface wb_if ();

    custom_pipe_unit #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .decode_stage      (decode_stage),
        .unit_needed       (unit_needed),
        .uses_rs           (uses_rs),
        .uses_rd           (uses_rd),
        .issue_stage       (issue_stage),
        .issue_stage_ready (issue_stage_ready),
        .rf                (rf),
        .issue             (issue_if),
        .wb                (wb_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     rd;
        logic [ID_W-1:0] id;
    } exp_t;

    typedef struct {
        logic [2:0]  fn3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs [14];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cycles = 0;
    int first_done = -1;
    int last_done = -1;
    int stall_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Independent reference for the fn3 operations
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        longint      sa;
        case (f)
            3'd0: r = a + b;
            3'd1: r = a + ~b + 32'd1;
            3'd2: r = a ^ b;
            3'd3: begin
`ifdef CUSTOM_PIPE_UNIT_SAT_EN
                sa = longint'($signed(a)) + longint'($signed(b));
                if (sa > 64'sd2147483647)       r = 32'h7FFF_FFFF;
                else if (sa < -64'sd2147483648) r = 32'h8000_0000;
                else                            r = sa[31:0];
`else
                sa = 0;
                r = a + b;
`endif
            end
            3'd4: r = ($signed(a) <= $signed(b)) ? a : b;
            3'd5: r = ($signed(a) >= $signed(b)) ? a : b;
            3'd6: r = (a <= b) ? a : b;
            default: begin
                r = a;
                for (int k = 0; k < int'(b[4:0]); k++) r = {r[30:0], r[31]};
            end
        endcase
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Writeback monitor: one line per retired result, compared with the scoreboard
    always @(negedge clk) begin
        if (wb_if.done === 1'b1) begin
            done_cycles++;
            if (first_done < 0) first_done = cyc;
            last_done = cyc;
        end
        if (wb_if.done === 1'b1 && wb_if.ack === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stale_result: got rd=%h id=%0d want no result", wb_if.rd, wb_if.id);
            end else begin
                mon_e = sb.pop_front();
                $display("retire cyc=%0d rd=%h id=%0d (want rd=%h id=%0d)", cyc, wb_if.rd, wb_if.id, mon_e.rd, mon_e.id);
                check("wb_rd", wb_if.rd, mon_e.rd);
                check("wb_id", 32'(wb_if.id), 32'(mon_e.id));
            end
        end
    end

    task automatic do_issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [ID_W-1:0] id, input logic [31:0] exp_rd);
        int waitc;
        waitc = 0;
        while (issue_if.ready !== 1'b1 && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        stall_cycles += waitc;
        if (issue_if.ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL issue_ready_timeout: got ready=%b want 1", issue_if.ready);
        end else begin
            issue_stage.fn3 = f;
            rf[RS1] = a;
            rf[RS2] = b;
            issue_if.id = id;
            issue_if.new_request = 1'b1;
            issue_stage_ready = 1'b1;
            sb.push_back('{rd: exp_rd, id: id});
            @(posedge clk); #1;
            issue_if.new_request = 1'b0;
            issue_stage_ready = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(sb.size() == 0 && wb_if.done === 1'b0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] dec_instr [4];
        logic [3:0]  dec_exp [4];
        int base;

        vecs[0]  = '{3'b000, 32'd5, 32'd7, 32'd12};
        vecs[1]  = '{3'b001, 32'd5, 32'd7, 32'hFFFF_FFFE};
        vecs[2]  = '{3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00};
`ifdef CUSTOM_PIPE_UNIT_SAT_EN
        vecs[3]  = '{3'b011, 32'h7FFF_FFF0, 32'h20, 32'h7FFF_FFFF};
        vecs[8]  = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
`else
        vecs[3]  = '{3'b011, 32'h7FFF_FFF0, 32'h20, 32'h8000_0010};
        vecs[8]  = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
`endif
        vecs[4]  = '{3'b100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
        vecs[5]  = '{3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1};
        vecs[6]  = '{3'b110, 32'hFFFF_FFFF, 32'd1, 32'd1};
        vecs[7]  = '{3'b111, 32'h8000_0001, 32'd4, 32'h0000_0018};
        vecs[9]  = '{3'b111, 32'h1234_5678, 32'd0, 32'h1234_5678};
        vecs[10] = '{3'b111, 32'h1234_5678, 32'h24, 32'h2345_6781};
        vecs[11] = '{3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        vecs[12] = '{3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
        vecs[13] = '{3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};

        dec_instr[0] = 32'h1234_568B; dec_exp[0] = 4'b1111;
        dec_instr[1] = 32'h0000_0033; dec_exp[1] = 4'b0000;
        dec_instr[2] = 32'h0000_002B; dec_exp[2] = 4'b0000;
        dec_instr[3] = 32'hFFFF_FF8B; dec_exp[3] = 4'b1111;

        rst = 1'b1;
        decode_stage = '0;
        issue_stage = '0;
        issue_stage_ready = 1'b0;
        rf[RS1] = '0;
        rf[RS2] = '0;
        issue_if.new_request = 1'b0;
        issue_if.id = '0;
        wb_if.ack = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(issue_if.ready), 32'd1);
        check("reset_done", 32'(wb_if.done), 32'd0);

        // Decode flags
        for (int i = 0; i < 4; i++) begin
            decode_stage.instruction = dec_instr[i];
            #1;
            check("decode_flags", 32'({unit_needed, uses_rs, uses_rd}), 32'(dec_exp[i]));
        end
        @(posedge clk); #1;

        // Single issue: done exactly LATENCY cycles after issue, drops after ack
        do_issue(3'b000, 32'd5, 32'd7, 3'd3, 32'd12);
        @(negedge clk);
        check("single_done_n1", 32'(wb_if.done), 32'd0);
        @(posedge clk); #1;
        wb_if.ack = 1'b1;
        @(negedge clk);
        check("single_done_n2", 32'(wb_if.done), 32'd1);
        check("single_rd", wb_if.rd, 32'd12);
        check("single_id", 32'(wb_if.id), 32'd3);
        @(posedge clk); #1;
        wb_if.ack = 1'b0;
        @(negedge clk);
        check("single_done_n3", 32'(wb_if.done), 32'd0);
        @(posedge clk); #1;

        // Table vectors, back to back with ack held high
        wb_if.ack = 1'b1;
        for (int i = 0; i < 14; i++) begin
            do_issue(vecs[i].fn3, vecs[i].a, vecs[i].b, ID_W'(i), vecs[i].exp);
        end
        wait_drain("table_drain");

        // Back-pressure: ack low, offer an issue every cycle
        wb_if.ack = 1'b0;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            if (issue_if.ready === 1'b1) begin
                f = 3'(i);
                a = 32'h100 + 32'(i);
                b = 32'd3;
                issue_stage.fn3 = f;
                rf[RS1] = a;
                rf[RS2] = b;
                issue_if.id = ID_W'(i);
                issue_if.new_request = 1'b1;
                issue_stage_ready = 1'b1;
                sb.push_back('{rd: model(f, a, b), id: ID_W'(i)});
                accepted++;
            end else begin
                issue_if.new_request = 1'b0;
                issue_stage_ready = 1'b0;
            end
            @(posedge clk); #1;
        end
        issue_if.new_request = 1'b0;
        issue_stage_ready = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd4);
        check("bp_ready_low", 32'(issue_if.ready), 32'd0);
        wb_if.ack = 1'b1;
        @(negedge clk);
        check("bp_ready_first_ack", 32'(issue_if.ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_ready_after_ack", 32'(issue_if.ready), 32'd1);
        wait_drain("bp_drain");

        // Streaming: 100 random issues with continuous ack
        wb_if.ack = 1'b1;
        done_cycles = 0;
        first_done = -1;
        last_done = -1;
        stall_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            do_issue(f, a, b, ID_W'(i % 8), model(f, a, b));
        end
        wait_drain("stream_drain");
        check("stream_done_cycles", 32'(done_cycles), 32'd100);
        check("stream_done_span", 32'(last_done - first_done + 1), 32'd100);
        check("stream_stalls", 32'(stall_cycles), 32'd0);

        // Reset with 3 results queued and 1 in flight
        wb_if.ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_issue(3'b010, 32'hDEAD_0000 + 32'(i), 32'h0, ID_W'(i), 32'hDEAD_0000 + 32'(i));
        end
        check("rst_pre_done", 32'(wb_if.done), 32'd1);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_done", 32'(wb_if.done), 32'd0);
        check("rst_mid_ready", 32'(issue_if.ready), 32'd1);
        wb_if.ack = 1'b1;
        base = done_cycles;
        repeat (8) @(negedge clk);
        check("rst_no_stale", 32'(done_cycles - base), 32'd0);
        @(posedge clk); #1;
        do_issue(vecs[7].fn3, vecs[7].a, vecs[7].b, 3'd5, vecs[7].exp);
        wait_drain("post_rst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
